// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared types for the system bus arbiter.
//   state_e : arbiter FSM states (IDLE, SETUP, ACCESS, DONE)
//   owner_e : current bus owner encoding (NONE=0, VID=1, CPU=2, SPI=3)
//   OWNER_W : width of the owner encoding
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    localparam int OWNER_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic [OWNER_W-1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_SPI  = 2'd3
    } owner_e;

endpackage

// File: rtl/bus_arb_priority.sv
// -----------------------------------------------------------------------------
// bus_arb_priority
// Combinational winner selection for the bus arbiter.
// Fixed priority VID > CPU > SPI, except that an SPI request which has already
// been passed over SPI_MAX_SKIP times wins outright.
// Ports:
//   vid_req, cpu_req, spi_req : pending requests
//   skip_cnt                  : consecutive times a pending SPI request lost
//   winner                    : selected owner, OWN_NONE when nothing pending
// -----------------------------------------------------------------------------
module bus_arb_priority
    import bus_arb_pkg::*;
#(
    parameter int SPI_MAX_SKIP = 3,
    parameter int SKIP_W       = 2
) (
    input  logic              vid_req,
    input  logic              cpu_req,
    input  logic              spi_req,
    input  logic [SKIP_W-1:0] skip_cnt,
    output owner_e            winner
);

    logic spi_starved;
    assign spi_starved = spi_req && (skip_cnt == SKIP_W'(SPI_MAX_SKIP));

    always_comb begin
        // NOTE: default assignment first so no path leaves winner unassigned (no latch).
        winner = OWN_NONE;
        if (spi_starved) begin
            winner = OWN_SPI;
        end else if (vid_req) begin
            winner = OWN_VID;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else if (spi_req) begin
            winner = OWN_SPI;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Three-way bus arbiter (video fetch, CPU, SPI) driving one shared memory/IO
// bus. Each transaction runs IDLE -> SETUP (1 cycle) -> ACCESS (RAM or IO
// wait length) -> DONE (1 cycle, owner ack) -> IDLE. Transactions are not
// preemptible; requests are only sampled in IDLE.
// Ports:
//   clk_sys_i, reset_n_i              : clock, async active-low reset
//   vid_req_i/vid_addr_i/vid_ack_o    : video requester (read-only)
//   cpu_req_i/cpu_addr_i/cpu_we_i/... : CPU requester
//   spi_req_i/spi_addr_i/spi_we_i/... : SPI requester
//   dec_ram_en_i, dec_io_en_i,
//   dec_is_readonly_i                 : external decode of bus_addr_o
//   bus_addr_o                        : latched owner address
//   ram_oe_o, ram_we_o, io_cs_o,
//   io_we_o                           : access strobes, high only in ACCESS
//   owner_o                           : current owner (NONE in IDLE)
//   ro_violation_o                    : one-cycle pulse in DONE on a blocked write
// Build option:
//   ROM_WRITE_PROTECT_EN : block CPU writes to read-only regions and report
//                          them on ro_violation_o. SPI writes stay permitted so
//                          ROM images can be loaded.
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int RAM_WAIT_CYCLES = 2,
    parameter int IO_WAIT_CYCLES  = 4,
    parameter int SPI_MAX_SKIP    = 3
) (
    input  logic        clk_sys_i,
    input  logic        reset_n_i,
    input  logic        vid_req_i,
    input  logic [16:0] vid_addr_i,
    output logic        vid_ack_o,
    input  logic        cpu_req_i,
    input  logic [16:0] cpu_addr_i,
    input  logic        cpu_we_i,
    output logic        cpu_ack_o,
    input  logic        spi_req_i,
    input  logic [16:0] spi_addr_i,
    input  logic        spi_we_i,
    output logic        spi_ack_o,
    input  logic        dec_ram_en_i,
    input  logic        dec_io_en_i,
    input  logic        dec_is_readonly_i,
    output logic [16:0] bus_addr_o,
    output logic        ram_oe_o,
    output logic        ram_we_o,
    output logic        io_cs_o,
    output logic        io_we_o,
    output logic [1:0]  owner_o,
    output logic        ro_violation_o
);

    localparam int WAIT_MAX = (IO_WAIT_CYCLES > RAM_WAIT_CYCLES) ? IO_WAIT_CYCLES
                                                                 : RAM_WAIT_CYCLES;
    // +2 keeps the widths at least one bit even for zero-valued parameters.
    localparam int WAIT_W   = $clog2(WAIT_MAX + 2);
    localparam int SKIP_W   = $clog2(SPI_MAX_SKIP + 2);

    state_e              state_q;
    owner_e              owner_q;
    owner_e              winner;
    logic                we_q;
    logic [SKIP_W-1:0]   skip_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                access_last;
    logic                permitted;

    assign owner_o     = owner_q;
    // A wait count of 0 or 1 both end ACCESS so a zero parameter cannot wrap.
    assign access_last = (state_q == ST_ACCESS) && (wait_q <= WAIT_W'(1));

    bus_arb_priority #(
        .SPI_MAX_SKIP (SPI_MAX_SKIP),
        .SKIP_W       (SKIP_W)
    ) u_priority (
        .vid_req  (vid_req_i),
        .cpu_req  (cpu_req_i),
        .spi_req  (spi_req_i),
        .skip_cnt (skip_q),
        .winner   (winner)
    );

`ifdef ROM_WRITE_PROTECT_EN
    // Only the CPU is blocked; video never writes and SPI loads ROM contents.
    assign permitted = !((owner_q == OWN_CPU) && dec_is_readonly_i);

    logic ro_q;
    assign ro_violation_o = ro_q;

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ro_q <= 1'b0;
        end else begin
            // Raised on the ACCESS->DONE edge so the pulse coincides with the ack.
            ro_q <= access_last && we_q && !permitted;
        end
    end
`else
    assign permitted      = 1'b1;
    assign ro_violation_o = 1'b0;
`endif

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            we_q       <= 1'b0;
            skip_q     <= '0;
            wait_q     <= '0;
            bus_addr_o <= '0;
            ram_oe_o   <= 1'b0;
            ram_we_o   <= 1'b0;
            io_cs_o    <= 1'b0;
            io_we_o    <= 1'b0;
            vid_ack_o  <= 1'b0;
            cpu_ack_o  <= 1'b0;
            spi_ack_o  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register updates from pre-edge values regardless of statement order.
            vid_ack_o <= 1'b0;
            cpu_ack_o <= 1'b0;
            spi_ack_o <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (winner != OWN_NONE) begin
                        owner_q <= winner;
                        state_q <= ST_SETUP;
                        unique case (winner)
                            OWN_VID: begin
                                bus_addr_o <= vid_addr_i;
                                we_q       <= 1'b0;
                            end
                            OWN_CPU: begin
                                bus_addr_o <= cpu_addr_i;
                                we_q       <= cpu_we_i;
                            end
                            default: begin
                                bus_addr_o <= spi_addr_i;
                                we_q       <= spi_we_i;
                            end
                        endcase
                        // Track how often a waiting SPI request loses.
                        if (winner == OWN_SPI) begin
                            skip_q <= '0;
                        end else if (spi_req_i && (skip_q != SKIP_W'(SPI_MAX_SKIP))) begin
                            skip_q <= skip_q + 1'b1;
                        end
                    end
                end

                ST_SETUP: begin
                    // Decode has settled on bus_addr_o; register the strobes for ACCESS.
                    state_q  <= ST_ACCESS;
                    wait_q   <= dec_io_en_i ? WAIT_W'(IO_WAIT_CYCLES)
                                            : WAIT_W'(RAM_WAIT_CYCLES);
                    ram_oe_o <= dec_ram_en_i && !we_q;
                    ram_we_o <= dec_ram_en_i && we_q && permitted;
                    io_cs_o  <= dec_io_en_i;
                    io_we_o  <= dec_io_en_i && we_q;
                end

                ST_ACCESS: begin
                    if (access_last) begin
                        state_q   <= ST_DONE;
                        ram_oe_o  <= 1'b0;
                        ram_we_o  <= 1'b0;
                        io_cs_o   <= 1'b0;
                        io_we_o   <= 1'b0;
                        vid_ack_o <= (owner_q == OWN_VID);
                        cpu_ack_o <= (owner_q == OWN_CPU);
                        spi_ack_o <= (owner_q == OWN_SPI);
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter with default parameters. Each granted
// transaction pushes its expected owner/address to a scoreboard queue; a
// monitor pops and compares whenever an ack appears. Scenario tasks also
// compare the per-cycle strobe/ack/owner pattern against the cycle numbering
// where cycle 0 is the IDLE cycle with the request high.
// Honours ROM_WRITE_PROTECT_EN when compiled with it.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int RAM_W = 2;
    localparam int IO_W  = 4;

    typedef struct {
        owner_e      owner;
        logic [16:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_req = 1'b0, cpu_req = 1'b0, spi_req = 1'b0;
    logic [16:0] vid_addr = '0, cpu_addr = '0, spi_addr = '0;
    logic        cpu_we = 1'b0, spi_we = 1'b0;
    logic        dec_ram = 1'b0, dec_io = 1'b0, dec_ro = 1'b0;
    logic        vid_ack, cpu_ack, spi_ack;
    logic [16:0] bus_addr;
    logic        ram_oe, ram_we, io_cs, io_we, ro_viol;
    logic [1:0]  owner;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk_sys_i         (clk),
        .reset_n_i         (rst_n),
        .vid_req_i         (vid_req),
        .vid_addr_i        (vid_addr),
        .vid_ack_o         (vid_ack),
        .cpu_req_i         (cpu_req),
        .cpu_addr_i        (cpu_addr),
        .cpu_we_i          (cpu_we),
        .cpu_ack_o         (cpu_ack),
        .spi_req_i         (spi_req),
        .spi_addr_i        (spi_addr),
        .spi_we_i          (spi_we),
        .spi_ack_o         (spi_ack),
        .dec_ram_en_i      (dec_ram),
        .dec_io_en_i       (dec_io),
        .dec_is_readonly_i (dec_ro),
        .bus_addr_o        (bus_addr),
        .ram_oe_o          (ram_oe),
        .ram_we_o          (ram_we),
        .io_cs_o           (io_cs),
        .io_we_o           (io_we),
        .owner_o           (owner),
        .ro_violation_o    (ro_viol)
    );

    function automatic logic [2:0] ack_of(input owner_e o);
        case (o)
            OWN_VID: return 3'b100;
            OWN_CPU: return 3'b010;
            OWN_SPI: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Scoreboard monitor: every ack must match the oldest expected grant.
    always @(negedge clk) begin
        logic [2:0] acks;
        exp_t       e;
        acks = {vid_ack, cpu_ack, spi_ack};
        if (acks != 3'b000) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_ack: acks=%b owner=%0d, required no ack", acks, owner);
            end else begin
                e = sb_q.pop_front();
                if ({acks, owner, bus_addr} !== {ack_of(e.owner), e.owner, e.addr}) begin
                    n_fail++;
                    $display("FAIL sb_grant: acks=%b owner=%0d addr=%h, required acks=%b owner=%0d addr=%h",
                             acks, owner, bus_addr, ack_of(e.owner), e.owner, e.addr);
                end
            end
        end
    end

    // One isolated transaction with full per-cycle checking.
    task automatic run_single(input string name, input owner_e who, input logic [16:0] addr,
                              input logic we, input logic ram, input logic io, input logic ro,
                              input bit drop_early);
        int         n;
        logic       perm, in_acc, done_c;
        logic [9:0] got, exp;
        dec_ram = ram;
        dec_io  = io;
        dec_ro  = ro;
        n = io ? IO_W : RAM_W;
`ifdef ROM_WRITE_PROTECT_EN
        perm = !((who == OWN_CPU) && ro);
`else
        perm = 1'b1;
`endif
        case (who)
            OWN_VID: begin vid_addr = addr; vid_req = 1'b1; end
            OWN_CPU: begin cpu_addr = addr; cpu_we = we; cpu_req = 1'b1; end
            default: begin spi_addr = addr; spi_we = we; spi_req = 1'b1; end
        endcase
        sb_q.push_back('{owner: who, addr: addr});
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            in_acc = (c >= 2) && (c <= n + 1);
            done_c = (c == n + 2);
            exp = {in_acc & ram & ~we, in_acc & ram & we & perm, in_acc & io, in_acc & io & we,
                   done_c ? ack_of(who) : 3'b000, done_c & we & ~perm,
                   (c <= n + 2) ? who : OWN_NONE};
            got = {ram_oe, ram_we, io_cs, io_we, vid_ack, cpu_ack, spi_ack, ro_viol, owner};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: oe,we,cs,iowe,acks,viol,owner=%b, required %b",
                         name, c, got, exp);
            end
            if (c == 1) begin
                n_tests++;
                if (bus_addr !== addr) begin
                    n_fail++;
                    $display("FAIL %s addr: got %h, required %h", name, bus_addr, addr);
                end
            end
            // Dropping the request after the grant must not abort the transaction.
            if ((c == 1 && drop_early) || done_c) begin
                vid_req = 1'b0;
                cpu_req = 1'b0;
                spi_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({ram_oe, ram_we, io_cs, io_we, vid_ack, cpu_ack, spi_ack, ro_viol, owner} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 0",
                     {ram_oe, ram_we, io_cs, io_we, vid_ack, cpu_ack, spi_ack, ro_viol, owner});
        end
        n_tests++;
        if (bus_addr !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h, required 0", bus_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (owner !== OWN_NONE) begin
            n_fail++;
            $display("FAIL reset_idle_owner: got %0d, required 0", owner);
        end
    endtask

    task automatic test_cpu_read;
        run_single("cpu_read", OWN_CPU, 17'h00100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_io_write;
        run_single("io_write", OWN_CPU, 17'h0E810, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_rom_protect;
        run_single("cpu_rom_write", OWN_CPU, 17'h0F000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_spi_rom_write;
        run_single("spi_rom_write", OWN_SPI, 17'h0F000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_vid_read;
        run_single("vid_read", OWN_VID, 17'h12345, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // All three requesters busy; each drops its request on ack and re-raises
    // it once the next grant is under way.
    task automatic test_priority_rotation;
        bit vid_down, cpu_down, spi_down;
        int acks_seen;
        vid_addr = 17'h00400; cpu_addr = 17'h01000; spi_addr = 17'h1F000;
        cpu_we = 1'b0; spi_we = 1'b0;
        dec_ram = 1'b1; dec_io = 1'b0; dec_ro = 1'b0;
        sb_q.push_back('{owner: OWN_VID, addr: 17'h00400});
        sb_q.push_back('{owner: OWN_CPU, addr: 17'h01000});
        sb_q.push_back('{owner: OWN_VID, addr: 17'h00400});
        sb_q.push_back('{owner: OWN_SPI, addr: 17'h1F000});
        vid_req = 1'b1; cpu_req = 1'b1; spi_req = 1'b1;
        vid_down = 1'b0; cpu_down = 1'b0; spi_down = 1'b0;
        acks_seen = 0;
        for (int c = 0; c < 80 && acks_seen < 4; c++) begin
            @(negedge clk);
            if (owner != OWN_NONE) begin
                if (vid_down) begin vid_req = 1'b1; vid_down = 1'b0; end
                if (cpu_down) begin cpu_req = 1'b1; cpu_down = 1'b0; end
                if (spi_down) begin spi_req = 1'b1; spi_down = 1'b0; end
            end
            if (vid_ack) begin vid_req = 1'b0; vid_down = 1'b1; acks_seen++; end
            if (cpu_ack) begin cpu_req = 1'b0; cpu_down = 1'b1; acks_seen++; end
            if (spi_ack) begin spi_req = 1'b0; spi_down = 1'b1; acks_seen++; end
        end
        vid_req = 1'b0; cpu_req = 1'b0; spi_req = 1'b0;
        n_tests++;
        if (acks_seen != 4) begin
            n_fail++;
            $display("FAIL rotation_timeout: got %0d acks, required 4", acks_seen);
        end
        @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rotation_pending: got %0d grants outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset_mid_access;
        dec_ram = 1'b1; dec_io = 1'b0; dec_ro = 1'b0;
        cpu_addr = 17'h02000; cpu_we = 1'b1; cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (ram_we !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_access_ram_we: got %b, required 1", ram_we);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus_addr, ram_oe, ram_we, io_cs, io_we, vid_ack, cpu_ack, spi_ack, ro_viol, owner} !== 27'b0) begin
            n_fail++;
            $display("FAIL reset_mid_access: got %h, required 0",
                     {bus_addr, ram_oe, ram_we, io_cs, io_we, vid_ack, cpu_ack, spi_ack, ro_viol, owner});
        end
        // Hold reset long enough that an un-aborted transaction would have acked.
        for (int c = 0; c < 5; c++) @(negedge clk);
        n_tests++;
        if (cpu_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_ack: got %b, required 0", cpu_ack);
        end
        rst_n = 1'b1;
        run_single("post_reset", OWN_CPU, 17'h02000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_io_write();
        test_rom_protect();
        test_spi_rom_write();
        test_vid_read();
        test_priority_rotation();
        test_reset_mid_access();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
